// File: rtl/udma_clkgen_mc_pkg.sv
// -----------------------------------------------------------------------------
// udma_clkgen_mc_pkg
// Shared types and constants for the multi-channel uDMA clock generator.
//   clkgen_state_e : per-channel reconfiguration FSM state
//   SYNC_STAGES    : depth of the cfg_valid_i synchroniser
//   div_is_bypass  : divisors below 2 select the undivided source clock
// -----------------------------------------------------------------------------
package udma_clkgen_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STOP = 2'd1,
        LOAD = 2'd2,
        WAIT = 2'd3
    } clkgen_state_e;

    localparam int unsigned SYNC_STAGES = 2;

    // A divisor of 0 or 1 cannot produce a divided clock, so it means bypass.
    function automatic logic div_is_bypass(input logic [31:0] div);
        return (div < 32'd2);
    endfunction

endpackage

// File: rtl/udma_clkgen_mc_if.sv
// -----------------------------------------------------------------------------
// udma_clkgen_mc_if
// Configuration handshake bundle between the SoC control registers (master)
// and the clock generator (slave).
//   cfg_div_i   : per-channel divisor, packed [NB_CH-1:0][DIV_W-1:0]
//   cfg_valid_i : per-channel asynchronous request level
//   cfg_ack_o   : synchronised echo of cfg_valid_i
//   busy_o      : channel reconfiguring or request pending
// -----------------------------------------------------------------------------
interface udma_clkgen_mc_if #(
    parameter int unsigned NB_CH = 4,
    parameter int unsigned DIV_W = 8
);
    logic [NB_CH-1:0][DIV_W-1:0] cfg_div_i;
    logic [NB_CH-1:0]            cfg_valid_i;
    logic [NB_CH-1:0]            cfg_ack_o;
    logic [NB_CH-1:0]            busy_o;

    modport master (
        output cfg_div_i,
        output cfg_valid_i,
        input  cfg_ack_o,
        input  busy_o
    );

    modport slave (
        input  cfg_div_i,
        input  cfg_valid_i,
        output cfg_ack_o,
        output busy_o
    );
endinterface

// File: rtl/pulp_clock_gating.sv
// -----------------------------------------------------------------------------
// pulp_clock_gating
// Latch-based integrated clock gate model.
//   clk_i     : clock to gate
//   en_i      : functional enable
//   test_en_i : test enable, forces the gate open
//   clk_o     : gated clock
// -----------------------------------------------------------------------------
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch_q;

    // Enable latch is transparent only while the clock is low, so clk_o never glitches.
    always_latch begin
        if (!clk_i) begin
            en_latch_q <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch_q;
endmodule

// File: rtl/pulp_clock_mux2.sv
// -----------------------------------------------------------------------------
// pulp_clock_mux2
// Two-input clock multiplexer cell model.
//   clk0_i    : selected when clk_sel_i = 0
//   clk1_i    : selected when clk_sel_i = 1
//   clk_sel_i : select
//   clk_o     : muxed clock
// -----------------------------------------------------------------------------
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/udma_clkgen_mc_ch.sv
// -----------------------------------------------------------------------------
// udma_clkgen_mc_ch
// One clock generator channel: request synchroniser, shadow divisor, FSM,
// divider counter, source mux and output clock gate.
// Optional macro UDMA_CLKGEN_DFT_EN adds a test-mode bypass mux and routes
// dft_cg_enable_i to the gate's test enable.
//   clk_i, rst_i        : source clock, async active-high reset
//   dft_test_mode_i     : test clock bypass (DFT build only)
//   dft_cg_enable_i     : gate test enable (DFT build only)
//   clock_enable_i      : functional gate enable
//   cfg_div_i           : requested divisor
//   cfg_valid_i         : asynchronous request level
//   cfg_ack_o           : synchronised echo of cfg_valid_i
//   busy_o              : reconfiguration running or pending
//   clk_o               : gated output clock
// -----------------------------------------------------------------------------
module udma_clkgen_mc_ch
    import udma_clkgen_mc_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dft_test_mode_i,
    input  logic             dft_cg_enable_i,
    input  logic             clock_enable_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ack_o,
    output logic             busy_o,
    output logic             clk_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   v_prev_q, v_prev_d;
    clkgen_state_e          state_q, state_d;
    logic [DIV_W-1:0]       div_sh_q, div_sh_d;
    logic [DIV_W-1:0]       div_act_q, div_act_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   div_clk_q, div_clk_d;
    logic                   sel_q, sel_d;          // 1: divided clock, 0: bypass
    logic                   gate_en_q, gate_en_d;
    logic                   busy_q, busy_d;
    logic                   req_s;
    logic [DIV_W-1:0]       cnt_next_s;
    logic                   src_clk_s;
    logic                   mux_clk_s;
    logic                   test_en_s;

    // Request detection, shadow capture and reconfiguration FSM.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], cfg_valid_i};
        v_prev_d  = sync_q[SYNC_STAGES-1];
        req_s     = sync_q[SYNC_STAGES-1] & ~v_prev_q;
        state_d   = state_q;
        div_sh_d  = div_sh_q;
        pending_d = pending_q;
        div_act_d = div_act_q;
        sel_d     = sel_q;

        // Any request, in any state, refreshes the shadow; only the latest is applied.
        if (req_s) begin
            div_sh_d  = cfg_div_i;
            pending_d = 1'b1;
        end else begin
            div_sh_d  = div_sh_q;
            pending_d = pending_q;
        end

        case (state_q)
            IDLE: begin
                if (pending_q || req_s) begin
                    state_d = STOP;
                end else begin
                    state_d = IDLE;
                end
            end
            STOP: state_d = LOAD;
            LOAD: begin
                div_act_d = div_sh_q;
                pending_d = req_s;
                sel_d     = div_is_bypass(32'(div_sh_q)) ? 1'b0 : 1'b1;
                state_d   = WAIT;
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        gate_en_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE) | pending_d;
    end

    // Divider: restarts high on LOAD, otherwise free-runs over div_act cycles.
    always_comb begin
        cnt_next_s = (cnt_q == (div_act_q - DIV_W'(1))) ? {DIV_W{1'b0}} : (cnt_q + DIV_W'(1));
        if (state_q == LOAD) begin
            cnt_d     = {DIV_W{1'b0}};
            div_clk_d = 1'b1;
        end else begin
            cnt_d     = cnt_next_s;
            div_clk_d = (cnt_next_s < (div_act_q >> 1'b1));
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= {SYNC_STAGES{1'b0}};
            v_prev_q  <= 1'b0;
            state_q   <= IDLE;
            div_sh_q  <= {DIV_W{1'b0}};
            div_act_q <= {DIV_W{1'b0}};
            cnt_q     <= {DIV_W{1'b0}};
            pending_q <= 1'b0;
            div_clk_q <= 1'b0;
            sel_q     <= 1'b0;
            gate_en_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            v_prev_q  <= v_prev_d;
            state_q   <= state_d;
            div_sh_q  <= div_sh_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            div_clk_q <= div_clk_d;
            sel_q     <= sel_d;
            gate_en_q <= gate_en_d;
            busy_q    <= busy_d;
        end
    end

    assign cfg_ack_o = sync_q[SYNC_STAGES-1];
    assign busy_o    = busy_q;

    pulp_clock_mux2 u_src_mux (
        .clk0_i    (clk_i),
        .clk1_i    (div_clk_q),
        .clk_sel_i (sel_q),
        .clk_o     (src_clk_s)
    );

`ifdef UDMA_CLKGEN_DFT_EN
    pulp_clock_mux2 u_dft_mux (
        .clk0_i    (src_clk_s),
        .clk1_i    (clk_i),
        .clk_sel_i (dft_test_mode_i),
        .clk_o     (mux_clk_s)
    );
    assign test_en_s = dft_cg_enable_i;
`else
    logic dft_unused_s;
    assign dft_unused_s = dft_test_mode_i | dft_cg_enable_i;
    assign mux_clk_s    = src_clk_s;
    assign test_en_s    = 1'b0;
`endif

    // clock_enable_i joins after the register; the gate latch keeps it glitch-free.
    pulp_clock_gating u_gate (
        .clk_i     (mux_clk_s),
        .en_i      (gate_en_q & clock_enable_i),
        .test_en_i (test_en_s),
        .clk_o     (clk_o)
    );
endmodule

// File: rtl/udma_clkgen_mc.sv
// -----------------------------------------------------------------------------
// udma_clkgen_mc
// Multi-channel uDMA peripheral clock generator: NB_CH independent gated,
// divided clocks derived from clk_i. Optional macro UDMA_CLKGEN_DFT_EN
// enables the per-channel DFT clock bypass.
//   clk_i, rst_i     : source clock, async active-high reset
//   dft_test_mode_i  : test clock bypass
//   dft_cg_enable_i  : clock-gate test enable
//   clock_enable_i   : per-channel functional gate enable
//   cfg              : configuration handshake bundle (slave side)
//   clk_o            : per-channel gated output clocks
// -----------------------------------------------------------------------------
module udma_clkgen_mc
    import udma_clkgen_mc_pkg::*;
#(
    parameter int unsigned NB_CH = 4,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dft_test_mode_i,
    input  logic             dft_cg_enable_i,
    input  logic [NB_CH-1:0] clock_enable_i,
    udma_clkgen_mc_if.slave  cfg,
    output logic [NB_CH-1:0] clk_o
);
    for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch
        udma_clkgen_mc_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .dft_test_mode_i (dft_test_mode_i),
            .dft_cg_enable_i (dft_cg_enable_i),
            .clock_enable_i  (clock_enable_i[ch]),
            .cfg_div_i       (cfg.cfg_div_i[ch]),
            .cfg_valid_i     (cfg.cfg_valid_i[ch]),
            .cfg_ack_o       (cfg.cfg_ack_o[ch]),
            .busy_o          (cfg.busy_o[ch]),
            .clk_o           (clk_o[ch])
        );
    end
endmodule

// File: tb/tb_udma_clkgen_mc.sv
// -----------------------------------------------------------------------------
// tb_udma_clkgen_mc
// Self-checking bench for udma_clkgen_mc: table of per-channel divisor
// requests with hand-computed clock shapes, plus sequences for the double
// request, reset in WAIT, all-channel requests, gate enable and DFT bypass.
// -----------------------------------------------------------------------------
module tb_udma_clkgen_mc;
    localparam int NB_CH = 4;
    localparam int DIV_W = 8;
    localparam int HALF  = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             dft_test_mode_i;
    logic             dft_cg_enable_i;
    logic [NB_CH-1:0] clock_enable_i;
    logic [NB_CH-1:0] clk_o;

    udma_clkgen_mc_if #(.NB_CH(NB_CH), .DIV_W(DIV_W)) cfg_if ();

    udma_clkgen_mc #(.NB_CH(NB_CH), .DIV_W(DIV_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dft_test_mode_i (dft_test_mode_i),
        .dft_cg_enable_i (dft_cg_enable_i),
        .clock_enable_i  (clock_enable_i),
        .cfg             (cfg_if),
        .clk_o           (clk_o)
    );

    always #(HALF) clk_i = ~clk_i;

    typedef struct {
        int ch;
        int div;
        int period;   // 0: expect clk_o to follow clk_i
        int high;
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;
    int   cur_div [NB_CH];

    // Pulse-width monitor on channel 1 to catch runt pulses.
    logic mon_en   = 1'b0;
    logic mon_have = 1'b0;
    time  mon_last = 0;
    time  min_w    = 1000;
    always @(clk_o[1]) begin
        if (mon_en) begin
            if (mon_have && (($time - mon_last) < min_w)) min_w = $time - mon_last;
            mon_have = 1'b1;
            mon_last = $time;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Bypass channels must be high just after every posedge.
    function automatic int others_bad(input int ch);
        int bad = 0;
        for (int c = 0; c < NB_CH; c++)
            if (c != ch && cur_div[c] < 2 && clk_o[c] !== 1'b1) bad++;
        return bad;
    endfunction

    task automatic chk_bypass(input string name, input int ch);
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clk_o[ch] !== 1'b1) bad++;
            @(negedge clk_i);
            #1;
            if (clk_o[ch] !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    task automatic measure(input string name, input int ch, input int per, input int hi);
        logic smp [40];
        int   k    = -1;
        int   errs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            smp[i] = clk_o[ch];
        end
        for (int i = 1; i <= per; i++)
            if (k < 0 && smp[i-1] === 1'b0 && smp[i] === 1'b1) k = i;
        if (k < 0) errs = 999;
        else
            for (int j = 0; j < 2 * per; j++)
                if (smp[k+j] !== (((j % per) < hi) ? 1'b1 : 1'b0)) errs++;
        chk(name, errs, 0);
    endtask

    // Full request handshake on one channel with timing checks; ends at T7+1.
    task automatic req(input int ch, input int div);
        int  gate_bad = 0;
        int  oth      = 0;
        logic was_byp = (cur_div[ch] < 2);
        cfg_if.cfg_div_i[ch]   = DIV_W'(div);
        cfg_if.cfg_valid_i[ch] = 1'b1;
        tick(); oth += others_bad(ch);                                          // T0
        chk($sformatf("ack_low_T0_ch%0d", ch), int'(cfg_if.cfg_ack_o[ch]), 0);
        tick(); oth += others_bad(ch);                                          // T1
        chk($sformatf("ack_high_T1_ch%0d", ch), int'(cfg_if.cfg_ack_o[ch]), 1);
        chk($sformatf("busy_low_T1_ch%0d", ch), int'(cfg_if.busy_o[ch]), 0);
        tick(); oth += others_bad(ch);                                          // T2
        chk($sformatf("busy_high_T2_ch%0d", ch), int'(cfg_if.busy_o[ch]), 1);
        for (int t = 3; t <= 5; t++) begin
            tick(); oth += others_bad(ch);
            if (clk_o[ch] !== 1'b0) gate_bad++;
        end
        if (was_byp) chk($sformatf("gate_closed_ch%0d", ch), gate_bad, 0);
        chk($sformatf("busy_low_T5_ch%0d", ch), int'(cfg_if.busy_o[ch]), 0);
        cfg_if.cfg_valid_i[ch] = 1'b0;
        tick(); oth += others_bad(ch);                                          // T6
        chk($sformatf("ack_hold_T6_ch%0d", ch), int'(cfg_if.cfg_ack_o[ch]), 1);
        tick(); oth += others_bad(ch);                                          // T7
        chk($sformatf("ack_drop_T7_ch%0d", ch), int'(cfg_if.cfg_ack_o[ch]), 0);
        chk($sformatf("others_undisturbed_ch%0d", ch), oth, 0);
        cur_div[ch] = div;
    endtask

    initial begin
        int bad;
        vecs[0] = '{ch: 0, div: 4, period: 4, high: 2};
        vecs[1] = '{ch: 1, div: 5, period: 5, high: 2};
        vecs[2] = '{ch: 1, div: 0, period: 0, high: 0};
        vecs[3] = '{ch: 2, div: 7, period: 7, high: 3};
        vecs[4] = '{ch: 3, div: 2, period: 2, high: 1};
        vecs[5] = '{ch: 0, div: 1, period: 0, high: 0};
        for (int c = 0; c < NB_CH; c++) cur_div[c] = 0;

        rst_i              = 1'b1;
        dft_test_mode_i    = 1'b0;
        dft_cg_enable_i    = 1'b0;
        clock_enable_i     = '1;
        cfg_if.cfg_div_i   = '0;
        cfg_if.cfg_valid_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;

        // Reset state.
        chk("reset_busy", int'(cfg_if.busy_o), 0);
        chk("reset_ack", int'(cfg_if.cfg_ack_o), 0);
        for (int c = 0; c < NB_CH; c++) chk_bypass($sformatf("reset_bypass_ch%0d", c), c);

        // Table of divisor requests.
        for (int v = 0; v < 6; v++) begin
            if (v == 1) begin
                mon_en   = 1'b1;
                mon_have = 1'b0;
            end
            req(vecs[v].ch, vecs[v].div);
            repeat (4) tick();
            if (vecs[v].period == 0)
                chk_bypass($sformatf("vec%0d_bypass_ch%0d", v, vecs[v].ch), vecs[v].ch);
            else
                measure($sformatf("vec%0d_shape_ch%0d", v, vecs[v].ch), vecs[v].ch,
                        vecs[v].period, vecs[v].high);
            if (v == 2) begin
                mon_en = 1'b0;
                checks++;
                if (min_w < HALF) begin
                    failures++;
                    $display("FAIL ch1_min_pulse actual=%0t required>=%0d", min_w, HALF);
                end
            end
        end

        // Ch2: div 6, then div 3 arriving during LOAD.
        cfg_if.cfg_div_i[2]   = 8'd6;
        cfg_if.cfg_valid_i[2] = 1'b1;
        tick();                                       // T0
        cfg_if.cfg_valid_i[2] = 1'b0;
        tick();                                       // T1
        chk("dbl_ack_T1", int'(cfg_if.cfg_ack_o[2]), 1);
        cfg_if.cfg_valid_i[2] = 1'b1;
        tick();                                       // T2
        chk("dbl_busy_T2", int'(cfg_if.busy_o[2]), 1);
        cfg_if.cfg_div_i[2] = 8'd3;
        bad = 0;
        for (int t = 3; t <= 8; t++) begin
            tick();
            if (cfg_if.busy_o[2] !== 1'b1) bad++;
        end
        chk("dbl_busy_T3_T8", bad, 0);
        tick();                                       // T9
        chk("dbl_busy_low_T9", int'(cfg_if.busy_o[2]), 0);
        cfg_if.cfg_valid_i[2] = 1'b0;
        repeat (4) tick();
        measure("dbl_final_shape_ch2", 2, 3, 1);
        cur_div[2] = 3;

        // All channels at once.
        cfg_if.cfg_div_i   = {8'd6, 8'd2, 8'd5, 8'd3};
        cfg_if.cfg_valid_i = 4'hF;
        tick(); tick();                               // T1
        chk("all_ack_T1", int'(cfg_if.cfg_ack_o), 15);
        tick();                                       // T2
        chk("all_busy_T2", int'(cfg_if.busy_o), 15);
        tick(); tick(); tick();                       // T5
        chk("all_busy_T5", int'(cfg_if.busy_o), 0);
        cfg_if.cfg_valid_i = 4'h0;
        repeat (4) tick();
        measure("all_shape_ch0", 0, 3, 1);
        measure("all_shape_ch3", 3, 6, 3);

        // Reset while ch3 sits in WAIT with div 8.
        cfg_if.cfg_div_i[3]   = 8'd8;
        cfg_if.cfg_valid_i[3] = 1'b1;
        repeat (5) tick();                            // T4: WAIT
        chk("rst_pre_busy_ch3", int'(cfg_if.busy_o[3]), 1);
        rst_i                 = 1'b1;
        cfg_if.cfg_valid_i[3] = 1'b0;
        #1;
        chk("rst_busy", int'(cfg_if.busy_o), 0);
        chk("rst_ack", int'(cfg_if.cfg_ack_o), 0);
        tick();
        chk("rst_clk_high", int'(clk_o), 15);
        @(negedge clk_i);
        #1;
        chk("rst_clk_low", int'(clk_o), 0);
        tick();
        rst_i = 1'b0;
        for (int c = 0; c < NB_CH; c++) cur_div[c] = 0;
        chk_bypass("post_rst_bypass_ch3", 3);
        chk("post_rst_busy", int'(cfg_if.busy_o), 0);

        // Functional gate enable only closes the gate.
        clock_enable_i[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clk_o[1] !== 1'b0) bad++;
        end
        chk("ce_low_ch1", bad, 0);
        chk("ce_low_busy", int'(cfg_if.busy_o[1]), 0);
        clock_enable_i[1] = 1'b1;
        chk_bypass("ce_restore_ch1", 1);

        // DFT test mode with div 4 active on ch0.
        req(0, 4);
        repeat (4) tick();
        measure("dft_pre_shape_ch0", 0, 4, 2);
        dft_test_mode_i = 1'b1;
        repeat (2) tick();
`ifdef UDMA_CLKGEN_DFT_EN
        chk_bypass("dft_bypass_ch0", 0);
`else
        measure("dft_ignored_shape_ch0", 0, 4, 2);
`endif
        dft_test_mode_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
